// File: rtl/fetch_sequencer.sv
// fetch_sequencer: fetches instructions over a req/ack handshake, issues them to
// control_unit, and updates the pc and the flag register from its decisions.
module fetch_sequencer #(
    parameter int          DATA_W  = 6,
    parameter int          PC_W    = 6,
    parameter logic [3:0]  HALT_OP = 4'b1111
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run_i,
    output logic              imem_req_o,
    output logic [PC_W-1:0]   imem_addr_o,
    input  logic              imem_ack_i,
    input  logic [DATA_W+3:0] imem_data_i,
    output logic [3:0]        opcode_o,
    output logic [DATA_W-1:0] imm_o,
    output logic              instr_valid_o,
    input  logic              jmp_sel_i,
    input  logic              reg_en_i,
    input  logic              alu_cf_i,
    input  logic              alu_sf_i,
    input  logic              alu_zf_i,
    output logic              cf_o,
    output logic              sf_o,
    output logic              zf_o,
    output logic              halted_o
);
    typedef enum logic [1:0] {IDLE, FETCH, ISSUE, HALT} state_t;
    state_t              state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [3:0]          opcode_q, opcode_d;
    logic [DATA_W-1:0]   imm_q, imm_d;
    logic [2:0]          flags_q, flags_d;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pc_q     <= '0;
            opcode_q <= '0;
            imm_q    <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            opcode_q <= opcode_d;
            imm_q    <= imm_d;
            flags_q  <= flags_d;
        end
    end
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        opcode_d = opcode_q;
        imm_d    = imm_q;
        flags_d  = flags_q;
        case (state_q)
            IDLE: if (run_i) state_d = FETCH;
            FETCH: if (imem_ack_i) begin
                opcode_d = imem_data_i[DATA_W+3:DATA_W];
                imm_d    = imem_data_i[DATA_W-1:0];
                state_d  = ISSUE;
            end
            ISSUE: if (opcode_q == HALT_OP) begin
                state_d = HALT;
            end else begin
                // pc wraps naturally at 2**PC_W
                pc_d    = jmp_sel_i ? imm_q[PC_W-1:0] : pc_q + PC_W'(1);
                flags_d = reg_en_i ? {alu_cf_i, alu_sf_i, alu_zf_i} : flags_q;
                state_d = FETCH;
            end
            default: ;
        endcase
    end
    assign imem_req_o    = state_q == FETCH;
    assign instr_valid_o = state_q == ISSUE;
    assign halted_o      = state_q == HALT;
    assign imem_addr_o   = pc_q;
    assign opcode_o      = opcode_q;
    assign imm_o         = imm_q;
    assign {cf_o, sf_o, zf_o} = flags_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed scenarios for fetch_sequencer with hand-computed expectations.
module tb_fetch_sequencer;
    logic       clk = 1'b0, rst_n = 1'b0, run_i = 1'b0, imem_ack_i = 1'b0;
    logic [9:0] imem_data_i = '0;
    logic       jmp_sel_i = 1'b0, reg_en_i = 1'b0, alu_cf_i = 1'b0, alu_sf_i = 1'b0, alu_zf_i = 1'b0;
    logic       imem_req_o, instr_valid_o, cf_o, sf_o, zf_o, halted_o;
    logic [5:0] imem_addr_o, imm_o;
    logic [3:0] opcode_o;
    int vectors = 0, miscompares = 0;

    fetch_sequencer dut (
        .clk(clk), .rst_n(rst_n), .run_i(run_i), .imem_req_o(imem_req_o),
        .imem_addr_o(imem_addr_o), .imem_ack_i(imem_ack_i), .imem_data_i(imem_data_i),
        .opcode_o(opcode_o), .imm_o(imm_o), .instr_valid_o(instr_valid_o),
        .jmp_sel_i(jmp_sel_i), .reg_en_i(reg_en_i), .alu_cf_i(alu_cf_i),
        .alu_sf_i(alu_sf_i), .alu_zf_i(alu_zf_i), .cf_o(cf_o), .sf_o(sf_o),
        .zf_o(zf_o), .halted_o(halted_o)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        step;
        rst_n = 1'b1;
    endtask

    // From IDLE: pulse run and confirm the first fetch starts at address 0.
    task automatic start_run;
        run_i = 1'b1;
        step;
        run_i = 1'b0;
        vectors++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 6'd0) begin
            miscompares++;
            $display("FAIL start_run: req=%b addr=%0d, required req=1 addr=0", imem_req_o, imem_addr_o);
        end
    endtask

    // Called at a negedge in FETCH: waits, acks word, checks ISSUE, drives control inputs.
    task automatic do_instr(input logic [9:0] word, input logic [5:0] exp_addr,
                            input logic [3:0] exp_op, input logic [5:0] exp_imm, input int waits,
                            input logic jmp, input logic ren,
                            input logic acf, input logic asf, input logic azf);
        for (int i = 0; i <= waits; i++) begin
            vectors++;
            if (imem_req_o !== 1'b1 || imem_addr_o !== exp_addr || instr_valid_o !== 1'b0) begin
                miscompares++;
                $display("FAIL fetch_wait%0d: req=%b addr=%0d valid=%b, required req=1 addr=%0d valid=0",
                         i, imem_req_o, imem_addr_o, instr_valid_o, exp_addr);
            end
            if (i < waits) step;
        end
        imem_ack_i  = 1'b1;
        imem_data_i = word;
        step;
        imem_ack_i  = 1'b0;
        vectors++;
        if (instr_valid_o !== 1'b1 || imem_req_o !== 1'b0 || opcode_o !== exp_op || imm_o !== exp_imm) begin
            miscompares++;
            $display("FAIL issue: valid=%b req=%b op=%h imm=%0d, required valid=1 req=0 op=%h imm=%0d",
                     instr_valid_o, imem_req_o, opcode_o, imm_o, exp_op, exp_imm);
        end
        jmp_sel_i = jmp; reg_en_i = ren;
        {alu_cf_i, alu_sf_i, alu_zf_i} = {acf, asf, azf};
        step;
        jmp_sel_i = 1'b0; reg_en_i = 1'b0;
        {alu_cf_i, alu_sf_i, alu_zf_i} = 3'b000;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        step;
        vectors++;
        if ({imem_req_o, instr_valid_o, halted_o, cf_o, sf_o, zf_o} !== 6'b0 ||
            imem_addr_o !== 6'd0 || opcode_o !== 4'd0 || imm_o !== 6'd0) begin
            miscompares++;
            $display("FAIL reset: req=%b valid=%b halted=%b flags=%b%b%b addr=%0d op=%h imm=%0d, required all 0",
                     imem_req_o, instr_valid_o, halted_o, cf_o, sf_o, zf_o, imem_addr_o, opcode_o, imm_o);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_idle;
        int bad = 0;
        for (int i = 0; i < 10; i++) begin
            imem_ack_i = (i >= 5);
            step;
            if (imem_req_o !== 1'b0 || instr_valid_o !== 1'b0 || imem_addr_o !== 6'd0) bad++;
        end
        imem_ack_i = 1'b0;
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL idle_no_run: %0d bad cycles, required 0", bad);
        end
    endtask

    task automatic test_program;
        start_run;
        do_instr(10'h005, 6'd0, 4'd0, 6'd5, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        do_instr(10'h102, 6'd1, 4'd4, 6'd2, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        do_instr(10'h3C0, 6'd2, 4'd15, 6'd0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        vectors++;
        if (halted_o !== 1'b1 || imem_req_o !== 1'b0 || imem_addr_o !== 6'd2 || {cf_o, sf_o, zf_o} !== 3'b000) begin
            miscompares++;
            $display("FAIL halt: halted=%b req=%b addr=%0d flags=%b%b%b, required halted=1 req=0 addr=2 flags=000",
                     halted_o, imem_req_o, imem_addr_o, cf_o, sf_o, zf_o);
        end
    endtask

    task automatic test_halt_stray;
        int bad = 0;
        run_i = 1'b1; imem_ack_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step;
            if (halted_o !== 1'b1 || imem_req_o !== 1'b0 || instr_valid_o !== 1'b0 || imem_addr_o !== 6'd2) bad++;
        end
        run_i = 1'b0; imem_ack_i = 1'b0;
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL halt_stray: %0d bad cycles, required 0", bad);
        end
    endtask

    task automatic test_ack_delay;
        int valids = 0;
        do_reset;
        start_run;
        do_instr(10'h0C7, 6'd0, 4'd3, 6'd7, 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            if (instr_valid_o === 1'b1) valids++;
            step;
        end
        vectors++;
        if (valids != 0 || imem_addr_o !== 6'd1 || imem_req_o !== 1'b1) begin
            miscompares++;
            $display("FAIL ack_delay_after: extra_valids=%0d addr=%0d req=%b, required 0 1 1",
                     valids, imem_addr_o, imem_req_o);
        end
    endtask

    task automatic test_jump;
        do_reset;
        start_run;
        do_instr({4'h2, 6'd40}, 6'd0, 4'h2, 6'd40, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        do_instr({4'h3, 6'd63}, 6'd40, 4'h3, 6'd63, 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        do_instr({4'h1, 6'd10}, 6'd63, 4'h1, 6'd10, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        do_instr({4'h2, 6'd0}, 6'd0, 4'h2, 6'd0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (imem_addr_o !== 6'd0 || imem_req_o !== 1'b1) begin
            miscompares++;
            $display("FAIL jump_self: addr=%0d req=%b, required addr=0 req=1", imem_addr_o, imem_req_o);
        end
    endtask

    task automatic test_flags;
        do_reset;
        start_run;
        do_instr(10'h041, 6'd0, 4'h1, 6'd1, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        vectors++;
        if ({cf_o, sf_o, zf_o} !== 3'b101) begin
            miscompares++;
            $display("FAIL flags_commit: flags=%b%b%b, required 101", cf_o, sf_o, zf_o);
        end
        do_instr(10'h081, 6'd1, 4'h2, 6'd1, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        vectors++;
        if ({cf_o, sf_o, zf_o} !== 3'b101) begin
            miscompares++;
            $display("FAIL flags_hold: flags=%b%b%b, required 101", cf_o, sf_o, zf_o);
        end
        do_instr(10'h081, 6'd2, 4'h2, 6'd1, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        vectors++;
        if ({cf_o, sf_o, zf_o} !== 3'b010 || imem_addr_o !== 6'd3) begin
            miscompares++;
            $display("FAIL flags_commit2: flags=%b%b%b addr=%0d, required 010 addr=3", cf_o, sf_o, zf_o, imem_addr_o);
        end
    endtask

    task automatic test_async_reset;
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (imem_req_o !== 1'b0 || imem_addr_o !== 6'd0 || halted_o !== 1'b0 || instr_valid_o !== 1'b0 ||
            {cf_o, sf_o, zf_o} !== 3'b000) begin
            miscompares++;
            $display("FAIL async_reset: req=%b addr=%0d halted=%b valid=%b flags=%b%b%b, required all 0",
                     imem_req_o, imem_addr_o, halted_o, instr_valid_o, cf_o, sf_o, zf_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        imem_ack_i = 1'b1;
        step;
        step;
        imem_ack_i = 1'b0;
        vectors++;
        if (imem_req_o !== 1'b0 || instr_valid_o !== 1'b0 || imem_addr_o !== 6'd0) begin
            miscompares++;
            $display("FAIL idle_stray_ack: req=%b valid=%b addr=%0d, required 0 0 0",
                     imem_req_o, instr_valid_o, imem_addr_o);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_idle;
        test_program;
        test_halt_stray;
        test_ack_delay;
        test_jump;
        test_flags;
        test_async_reset;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
